typed_text_buffer: RTL

//  Producer of the 125-bit packed text vector (25 slots x 5-bit letter code, code 0='A'..25='Z').

---
 rtl/typer_pkg.sv | 62 ++++++
 rtl/ps2_prefix_fsm.sv | 70 +++++++
 rtl/typed_text_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/typer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : typer_pkg
// Description : Shared constants, PS/2 set-2 scancode helpers and the
//               prefix-FSM state type used by the typed-text buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package typer_pkg;

    localparam int CHAR_W = 5;
    localparam int SLOTS  = 25;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    // Returns {hit, code}: hit=1 when sc is a letter key, code 0='A'..25='Z'.
    function automatic logic [CHAR_W:0] sc2letter(input logic [7:0] sc);
        logic [CHAR_W:0] r;
        r = '0;
        case (sc)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_prefix_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ps2_prefix_fsm
// Description : Strips PS/2 set-2 break (F0) and extended (E0) prefixes from
//               an accepted byte stream and flags plain make codes.
// Ports       : clk, rst (async, active-high)
//               byte_valid  - a byte is accepted this cycle
//               byte_data   - the accepted byte
//               clear       - return to IDLE synchronously
//               make_valid  - byte_data is a plain (non-extended) make code
//               make_code   - the make code itself
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_prefix_fsm
    import typer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       clear,
    output logic       make_valid,
    output logic [7:0] make_code
);

    ps2_state_e state_q;
    ps2_state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        make_valid = 1'b0;
        make_code  = byte_data;
        if (clear) begin
            state_d = IDLE;
        end else if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_data == SC_BRK) begin
                        state_d = BRK;
                    end else if (byte_data == SC_EXT) begin
                        state_d = EXT;
                    end else begin
                        make_valid = 1'b1;
                    end
                end
                // Extended keys (arrows etc.) are never acted on.
                EXT: begin
                    if (byte_data == SC_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BRK:     state_d = IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/typed_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : typed_text_buffer
// Description : Collects typed letters from a PS/2 set-2 scancode stream into
//               a packed SLOTS x 5-bit text vector with Backspace and Enter.
// Ports       : clk, rst (async, active-high)
//               key_valid/key_data/key_ready - scancode byte handshake
//               clear       - synchronous buffer wipe (blocks key_ready)
//               target      - expected text, for mistype counting
//               text/len/full - buffer contents, fill level, full flag
//               enter_pulse - one-cycle pulse per Enter make code
//               err_count   - mistyped-letter count (saturating)
// Config      : TTB_ERRCNT_EN - enables err_count; otherwise tied to 0 and
//               target is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module typed_text_buffer #(
    parameter int SLOTS = typer_pkg::SLOTS,
    parameter int LEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [7:0]         key_data,
    output logic               key_ready,
    input  logic               clear,
    input  logic [5*SLOTS-1:0] target,
    output logic [5*SLOTS-1:0] text,
    output logic [LEN_W-1:0]   len,
    output logic               full,
    output logic               enter_pulse,
    output logic [7:0]         err_count
);

    import typer_pkg::*;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SLOTS);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic                  w_accept;
    logic                  w_make_valid;
    logic [7:0]            w_make_code;
    logic [CHAR_W:0]       w_letter;
    logic                  w_hit;
    logic [CHAR_W-1:0]     w_code;
    logic                  w_append;

    logic [CHAR_W*SLOTS-1:0] text_q, text_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    enter_q, enter_d;

    assign key_ready = ~clear;
    assign w_accept  = key_valid & key_ready;

    ps2_prefix_fsm u_prefix (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (w_accept),
        .byte_data  (key_data),
        .clear      (clear),
        .make_valid (w_make_valid),
        .make_code  (w_make_code)
    );

    assign w_letter = sc2letter(w_make_code);
    assign w_hit    = w_letter[CHAR_W];
    assign w_code   = w_letter[CHAR_W-1:0];

    // Slots at or above len are kept at zero so the vector is clean even
    // for consumers that ignore len.
    always_comb begin
        text_d   = text_q;
        len_d    = len_q;
        enter_d  = 1'b0;
        w_append = 1'b0;
        if (clear) begin
            text_d = '0;
            len_d  = '0;
        end else if (w_make_valid) begin
            if (w_hit) begin
                if (len_q != LEN_MAX) begin
                    text_d[CHAR_W*len_q +: CHAR_W] = w_code;
                    len_d    = len_q + LEN_ONE;
                    w_append = 1'b1;
                end
            end else if (w_make_code == SC_BKSP) begin
                if (len_q != '0) begin
                    len_d = len_q - LEN_ONE;
                    text_d[CHAR_W*len_d +: CHAR_W] = '0;
                end
            end else if (w_make_code == SC_ENTER) begin
                enter_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_q  <= '0;
            len_q   <= '0;
            enter_q <= 1'b0;
        end else begin
            text_q  <= text_d;
            len_q   <= len_d;
            enter_q <= enter_d;
        end
    end

    assign text        = text_q;
    assign len         = len_q;
    assign full        = (len_q == LEN_MAX);
    assign enter_pulse = enter_q;

`ifdef TTB_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // Compared against the target slot being written; Backspace never
    // refunds a mistake.
    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = '0;
        end else if (w_append && (w_code != target[CHAR_W*len_q +: CHAR_W])
                     && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic w_unused_target;
    assign w_unused_target = ^{target, w_append};
    assign err_count       = 8'h00;
`endif

endmodule
`default_nettype wire
